// File: rtl/frequency_analyzer_pkg.sv
// Shared definitions for the frequency analyzer control path.
// Holds the scheduler state encoding, the default irq watchdog length and the
// register-block offsets that software uses to reach the scheduler controls.
package frequency_analyzer_pkg;

  // Scheduler states; the encoding is visible to software through the status register.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StSettle  = 3'd2,
    StMeasure = 3'd3,
    StStop    = 3'd4,
    StWaitIrq = 3'd5,
    StDone    = 3'd6
  } fa_state_e;

  // Cycles allowed between the stop pulse and the analyzer irq.
  localparam int unsigned DefaultIrqTimeout = 1024;

  // Register offsets (bytes) within the AXI register block.
  localparam logic [7:0] RegGoOffset          = 8'h00;
  localparam logic [7:0] RegAbortOffset       = 8'h04;
  localparam logic [7:0] RegContinuousOffset  = 8'h08;
  localparam logic [7:0] RegSettleOffset      = 8'h0C;
  localparam logic [7:0] RegWindowOffset      = 8'h10;
  localparam logic [7:0] RegStatusOffset      = 8'h14;
  localparam logic [7:0] RegWindowCountOffset = 8'h18;

endpackage

// File: rtl/fa_down_counter.sv
// Loadable down-counter with a zero flag.
// Ports:
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   load_i        : load load_val_i (wins over dec_i)
//   load_val_i    : value to load
//   dec_i         : decrement by one; the caller keeps it low at zero
//   count_o       : current count
//   zero_o        : count_o == 0
module fa_down_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic [Width-1:0] count_o,
  output logic             zero_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i) begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/frequency_analyzer_scheduler.sv
// Measurement-window sequencer for frequency_analyzer_manager.
// Drives the analyzer clear/start/stop pulses, waits for its irq (with a
// watchdog), and reports completed windows to software. Single-shot or
// continuous back-to-back windows.
// Ports:
//   s00_axi_aclk, s00_axi_aresetn : clock, asynchronous active-low reset
//   go, abort                     : one-cycle software requests
//   continuous, settle_cycles,
//   window_cycles                 : configuration, latched on an accepted go
//   ack                           : software acknowledge of window_done
//   irq                           : analyzer result-ready level
//   clear, start, stop            : one-cycle pulses to the analyzer
//   busy                          : sequence in progress
//   window_done                   : window finished, held until ack
//   timeout_err                   : sticky irq watchdog error
//   window_count                  : completed windows, wrapping
module frequency_analyzer_scheduler
  import frequency_analyzer_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned IRQ_TIMEOUT  = DefaultIrqTimeout,
  parameter int unsigned WINCNT_WIDTH = 16
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic                    go,
  input  logic                    abort,
  input  logic                    continuous,
  input  logic [CNT_WIDTH-1:0]    settle_cycles,
  input  logic [CNT_WIDTH-1:0]    window_cycles,
  input  logic                    ack,
  input  logic                    irq,
  output logic                    clear,
  output logic                    start,
  output logic                    stop,
  output logic                    busy,
  output logic                    window_done,
  output logic                    timeout_err,
  output logic [WINCNT_WIDTH-1:0] window_count
);

  localparam logic [CNT_WIDTH-1:0]    CntOne  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    TmoLoad = CNT_WIDTH'(IRQ_TIMEOUT);
  localparam logic [WINCNT_WIDTH-1:0] WcntOne = WINCNT_WIDTH'(1);

  fa_state_e state_q, state_d;

  // Latched configuration
  logic                 cont_q;
  logic [CNT_WIDTH-1:0] settle_q;
  logic [CNT_WIDTH-1:0] window_q;
  logic                 cfg_load;

  logic                    irq_q;
  logic                    first_q, first_d;           // first MEASURE cycle -> start pulse
  logic                    abort_stop_q, abort_stop_d; // STOP reached via abort, skip WAIT_IRQ
  logic                    err_q, err_d;
  logic [WINCNT_WIDTH-1:0] wcnt_q, wcnt_d;

  // Counter controls and status
  logic                 settle_load, settle_dec, settle_zero;
  logic                 win_load, win_dec, win_zero;
  logic                 tmo_load, tmo_dec, tmo_zero;
  logic [CNT_WIDTH-1:0] settle_cnt, win_cnt, tmo_cnt;
  logic                 settle_last, win_last, tmo_expired, irq_rise;

  fa_down_counter #(
    .Width (CNT_WIDTH)
  ) u_settle_cnt (
    .clk_i      (s00_axi_aclk),
    .rst_ni     (s00_axi_aresetn),
    .load_i     (settle_load),
    .load_val_i (settle_q),
    .dec_i      (settle_dec),
    .count_o    (settle_cnt),
    .zero_o     (settle_zero)
  );

  fa_down_counter #(
    .Width (CNT_WIDTH)
  ) u_window_cnt (
    .clk_i      (s00_axi_aclk),
    .rst_ni     (s00_axi_aresetn),
    .load_i     (win_load),
    .load_val_i (window_q),
    .dec_i      (win_dec),
    .count_o    (win_cnt),
    .zero_o     (win_zero)
  );

  fa_down_counter #(
    .Width (CNT_WIDTH)
  ) u_timeout_cnt (
    .clk_i      (s00_axi_aclk),
    .rst_ni     (s00_axi_aresetn),
    .load_i     (tmo_load),
    .load_val_i (TmoLoad),
    .dec_i      (tmo_dec),
    .count_o    (tmo_cnt),
    .zero_o     (tmo_zero)
  );

  // Zero is never loaded into the settle/window counters while they are in use;
  // treating it as "last" keeps the FSM from ever stalling there.
  assign settle_last = settle_zero || (settle_cnt == CntOne);
  assign win_last    = win_zero || (win_cnt == CntOne);
  assign tmo_expired = (tmo_cnt == '0);
  assign irq_rise    = irq && !irq_q;

  always_comb begin
    state_d      = state_q;
    cfg_load     = 1'b0;
    first_d      = 1'b0;
    abort_stop_d = 1'b0;
    err_d        = err_q;
    wcnt_d       = wcnt_q;
    settle_load  = 1'b0;
    settle_dec   = 1'b0;
    win_load     = 1'b0;
    win_dec      = 1'b0;
    tmo_load     = 1'b0;
    tmo_dec      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          cfg_load = 1'b1;
          err_d    = 1'b0;
          state_d  = StClear;
        end
      end
      StClear: begin
        settle_load = 1'b1;
        if (settle_q == '0) begin
          win_load = 1'b1;
          first_d  = 1'b1;
          state_d  = StMeasure;
        end else begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (settle_last) begin
          win_load = 1'b1;
          first_d  = 1'b1;
          state_d  = StMeasure;
        end else begin
          settle_dec = 1'b1;
        end
      end
      StMeasure: begin
        if (win_last) begin
          state_d = StStop;
        end else begin
          win_dec = 1'b1;
        end
      end
      StStop: begin
        tmo_load = 1'b1;
        state_d  = abort_stop_q ? StIdle : StWaitIrq;
      end
      StWaitIrq: begin
        // A result arriving on the last watchdog cycle still counts.
        if (irq_rise) begin
          wcnt_d  = wcnt_q + WcntOne;
          state_d = StDone;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_dec = !tmo_zero;
        end
      end
      StDone: begin
        if (ack) begin
          state_d = cont_q ? StClear : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides everything outside IDLE; an open window is still closed
    // with a stop pulse so the analyzer is not left counting.
    if (abort && (state_q != StIdle)) begin
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      first_d = 1'b0;
      if (state_q == StMeasure) begin
        abort_stop_d = 1'b1;
        state_d      = StStop;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q      <= StIdle;
      irq_q        <= 1'b0;
      first_q      <= 1'b0;
      abort_stop_q <= 1'b0;
      err_q        <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq;
      first_q      <= first_d;
      abort_stop_q <= abort_stop_d;
      err_q        <= err_d;
      wcnt_q       <= wcnt_d;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cont_q   <= 1'b0;
      settle_q <= '0;
      window_q <= '0;
    end else if (cfg_load) begin
      cont_q   <= continuous;
      settle_q <= settle_cycles;
      window_q <= (window_cycles == '0) ? CntOne : window_cycles;
    end
  end

  assign clear        = (state_q == StClear);
  assign start        = (state_q == StMeasure) && first_q;
  assign stop         = (state_q == StStop);
  assign busy         = (state_q != StIdle);
  assign window_done  = (state_q == StDone);
  assign timeout_err  = err_q;
  assign window_count = wcnt_q;

endmodule

// File: tb/tb_frequency_analyzer_scheduler.sv
module tb_frequency_analyzer_scheduler;

  localparam int unsigned CW  = 32;
  localparam int unsigned TMO = 16;
  localparam int unsigned WW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          continuous = 1'b0;
  logic [CW-1:0] settle_cycles = '0;
  logic [CW-1:0] window_cycles = '0;
  logic          ack = 1'b0;
  logic          irq = 1'b0;
  logic          clear, start, stop, busy, window_done, timeout_err;
  logic [WW-1:0] window_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: expected window count and sticky error
  logic [WW-1:0] wc_exp = '0;
  logic          err_exp = 1'b0;

  always #5 clk = ~clk;

  frequency_analyzer_scheduler #(
    .CNT_WIDTH    (CW),
    .IRQ_TIMEOUT  (TMO),
    .WINCNT_WIDTH (WW)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .go              (go),
    .abort           (abort),
    .continuous      (continuous),
    .settle_cycles   (settle_cycles),
    .window_cycles   (window_cycles),
    .ack             (ack),
    .irq             (irq),
    .clear           (clear),
    .start           (start),
    .stop            (stop),
    .busy            (busy),
    .window_done     (window_done),
    .timeout_err     (timeout_err),
    .window_count    (window_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a go with the given configuration in the current (idle) cycle.
  task automatic issue_go(input int s, input int w, input bit cont, input bit with_abort);
    settle_cycles = CW'(s);
    window_cycles = CW'(w);
    continuous    = cont;
    go            = 1'b1;
    abort         = with_abort;
  endtask

  // Timeline model of one window, k counted in cycles after the go / the ack that
  // started it. d: irq rises d cycles after stop (<=0 or >TMO+1: never, timeout).
  // a: ack delay after window_done rises. abort_k/go_k: cycle to pulse abort/go (0: none).
  task automatic run_window(input int s, input int w, input int d, input int a,
                            input int abort_k, input int go_k, input bit cont,
                            input bit from_go, input string tag, output bit more);
    int wl, sk, done_start, nat_end, end_k, last_k;
    bit irqmode, aborted, ab_meas, pre;
    logic [5:0] exp_v, got_v;
    wl         = (w == 0) ? 1 : w;
    sk         = 2 + s + wl;
    irqmode    = (d >= 1) && (d <= int'(TMO) + 1);
    done_start = sk + d + 1;
    nat_end    = irqmode ? done_start + a : sk + int'(TMO) + 1;
    aborted    = (abort_k > 0) && (abort_k <= nat_end);
    ab_meas    = aborted && (abort_k >= 2 + s) && (abort_k < sk);
    end_k      = aborted ? abort_k + (ab_meas ? 1 : 0) : nat_end;
    more       = cont && irqmode && !aborted;
    last_k     = more ? end_k : end_k + 1;
    for (int k = 1; k <= last_k; k++) begin
      step();
      go = 1'b0;
      abort = 1'b0;
      ack = 1'b0;
      pre = !aborted || (k <= abort_k);
      if (k == 1 && from_go) err_exp = 1'b0;
      if (irqmode && pre && k == done_start) wc_exp = wc_exp + 16'd1;
      if (k == end_k + 1 && !irqmode && !aborted) err_exp = 1'b1;
      if (k <= end_k) begin
        exp_v[5] = pre && (k == 1);
        exp_v[4] = pre && (k == 2 + s);
        exp_v[3] = (pre && (k == sk)) || (ab_meas && (k == abort_k + 1));
        exp_v[2] = 1'b1;
        exp_v[1] = irqmode && pre && (k >= done_start);
      end else begin
        exp_v[5:1] = 5'b0;
      end
      exp_v[0] = err_exp;
      got_v = {clear, start, stop, busy, window_done, timeout_err};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s k=%0d {clear,start,stop,busy,done,err} got %b expected %b",
                 tag, k, got_v, exp_v);
      end
      n_checks++;
      if (window_count !== wc_exp) begin
        n_fail++;
        $display("FAIL %s k=%0d window_count got %0d expected %0d", tag, k, window_count, wc_exp);
      end
      // Inputs for this cycle; config is scrambled to show it is latched.
      settle_cycles = CW'($urandom);
      window_cycles = CW'($urandom);
      continuous    = 1'($urandom);
      go    = (k == go_k) && (k <= end_k);
      abort = aborted && (k == abort_k);
      ack   = irqmode && (k == done_start + a) && (k <= end_k);
      irq   = irqmode && (k >= sk + d) && (k <= end_k);
    end
  endtask

  task automatic check_idle(input string tag);
    logic [5:0] got_v;
    got_v = {clear, start, stop, busy, window_done, timeout_err};
    n_checks++;
    if (got_v !== {5'b0, err_exp}) begin
      n_fail++;
      $display("FAIL %s outputs got %b expected %b", tag, got_v, {5'b0, err_exp});
    end
    n_checks++;
    if (window_count !== wc_exp) begin
      n_fail++;
      $display("FAIL %s window_count got %0d expected %0d", tag, window_count, wc_exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    check_idle("reset_held");
    #2 rst_n = 1'b1;
    step();
    check_idle("reset_released");
  endtask

  task automatic test_single_shot();
    bit more;
    issue_go(3, 10, 1'b0, 1'b0);
    run_window(3, 10, 5, 0, 0, 0, 1'b0, 1'b1, "single_shot", more);
  endtask

  task automatic test_zero_config();
    bit more;
    issue_go(0, 0, 1'b0, 1'b0);
    run_window(0, 0, 3, 1, 0, 0, 1'b0, 1'b1, "zero_config", more);
  endtask

  task automatic test_timeout();
    bit more;
    issue_go(2, 3, 1'b0, 1'b0);
    run_window(2, 3, -1, 0, 0, 0, 1'b0, 1'b1, "timeout", more);
    issue_go(1, 2, 1'b0, 1'b0);
    run_window(1, 2, 4, 2, 0, 0, 1'b0, 1'b1, "timeout_clear", more);
  endtask

  task automatic test_continuous();
    bit more;
    issue_go(2, 4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run_window(2, 4, 3 + i, i, 0, 0, 1'b1, i == 0, "continuous", more);
    end
    // Abort in the 3rd MEASURE cycle of the 4th window
    run_window(2, 4, 3, 0, 6, 0, 1'b1, 1'b0, "continuous_abort", more);
  endtask

  task automatic test_reset_mid();
    bit more;
    issue_go(4, 6, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      step();
      go = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre-reset busy got %b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    wc_exp  = '0;
    err_exp = 1'b0;
    check_idle("reset_mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_idle("reset_mid_after");
    issue_go(0, 2, 1'b0, 1'b0);
    run_window(0, 2, 2, 0, 0, 0, 1'b0, 1'b1, "after_reset", more);
  endtask

  task automatic test_go_ack_ignored();
    bit more;
    issue_go(5, 4, 1'b0, 1'b0);
    run_window(5, 4, 2, 1, 0, 4, 1'b0, 1'b1, "go_while_busy", more);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check_idle("ack_in_idle");
    step();
    check_idle("ack_in_idle_next");
  endtask

  task automatic test_go_abort_same();
    bit more;
    issue_go(1, 1, 1'b0, 1'b1);
    run_window(1, 1, 1, 0, 0, 0, 1'b0, 1'b1, "go_abort_idle", more);
  endtask

  task automatic test_random();
    bit more, cont;
    int s, w, d, a, ab;
    for (int it = 0; it < 20; it++) begin
      s    = $urandom_range(0, 6);
      w    = $urandom_range(0, 8);
      cont = 1'($urandom);
      issue_go(s, w, cont, 1'b0);
      for (int j = 0; j < 4; j++) begin
        d  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(1, TMO + 1);
        a  = $urandom_range(0, 3);
        if (cont && j == 3) ab = $urandom_range(1, 2 + s);
        else if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, 2 + s + w + 8);
        else ab = 0;
        run_window(s, w, d, a, ab, $urandom_range(0, 6), cont, j == 0, "random", more);
        if (!more) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_zero_config();
    test_timeout();
    test_continuous();
    test_reset_mid();
    test_go_ack_ignored();
    test_go_abort_same();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frequency_analyzer_scheduler.md
Name: frequency_analyzer_scheduler

Overview:
- Sequences measurement windows for frequency_analyzer_manager: drives its clear/start/stop controls, waits for its irq, then reports window completion to software.
- Sits between the AXI register block (go/abort/config) and the analyzer's control inputs.
- Supports single-shot and continuous back-to-back windows, with an irq timeout watchdog.

Parameters:
- CNT_WIDTH, 32, width of the settle and window cycle counters.
- IRQ_TIMEOUT, 1024, cycles to wait for the analyzer irq after stop before flagging an error.
- WINCNT_WIDTH, 16, width of the completed-window counter.

Ports:
- s00_axi_aclk  in  1  single clock for the whole block.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
- abort  in  1  one-cycle request to terminate the sequence from any state.
- continuous  in  1  latched at go: 1 = repeat windows until abort, 0 = single window.
- settle_cycles  in  CNT_WIDTH  cycles between clear and start; latched at go.
- window_cycles  in  CNT_WIDTH  cycles between start and stop; latched at go; 0 is treated as 1.
- ack  in  1  software acknowledge of window_done.
- irq  in  1  analyzer result-ready, synchronous to s00_axi_aclk; level.
- clear  out  1  one-cycle pulse to the analyzer.
- start  out  1  one-cycle pulse to the analyzer.
- stop  out  1  one-cycle pulse to the analyzer.
- busy  out  1  high in every state except IDLE.
- window_done  out  1  level, high in DONE until ack.
- timeout_err  out  1  sticky error flag; cleared on the next accepted go.
- window_count  out  WINCNT_WIDTH  number of completed windows; wraps.

Behaviour:
- Reset (async assert, sync deassert): FSM = IDLE; all outputs 0; counters and latched config cleared.
- States: IDLE, CLEAR, SETTLE, MEASURE, STOP, WAIT_IRQ, DONE.
- IDLE, go=1: latch config, clear timeout_err, go to CLEAR.
- CLEAR: clear=1 for exactly this cycle. Load counter = settle_cycles. Go to SETTLE, or straight to MEASURE if settle_cycles = 0.
- SETTLE: decrement each cycle; on counter = 1 go to MEASURE. Dwell is exactly settle_cycles cycles.
- MEASURE: start=1 in the first cycle only. Dwell is exactly max(window_cycles,1) cycles, then go to STOP.
- STOP: stop=1 for exactly this cycle. Load timeout counter = IRQ_TIMEOUT. Go to WAIT_IRQ.
- WAIT_IRQ, rising edge of irq: window_count += 1 (wraps), go to DONE.
  - Edge detect uses a registered irq copy, reset to 0.
  - An irq already high on WAIT_IRQ entry counts as an edge only if it was low in the previous cycle.
- WAIT_IRQ, timeout counter reaches 0: timeout_err=1, go to IDLE; window_count unchanged.
- DONE: window_done=1. On ack:
  - continuous=1: go to CLEAR.
  - otherwise: go to IDLE.
  - ack in the same cycle DONE is entered is honoured.
- Latency from go to clear pulse: 1 cycle. From go to start pulse: 2 + settle_cycles cycles.
- Abort, any non-IDLE state, next cycle:
  - from MEASURE: go to STOP, issue the stop pulse, then IDLE; no WAIT_IRQ, no window_count increment.
  - from any other state: go to IDLE directly.
- go while busy: ignored. go and abort in the same cycle in IDLE: abort has no effect, go is accepted.
- Config inputs changing mid-sequence have no effect until the next go. In continuous mode the latched values are reused.
- Reset mid-operation returns to IDLE immediately with all pulses deasserted. An analyzer left counting is cleared by the next CLEAR.
- clear, start and stop are never high in the same cycle.

Decomposition:
- Shared package frequency_analyzer_pkg holds:
  - state enum constants (IDLE=0 … DONE=6, 3 bits);
  - the default IRQ_TIMEOUT;
  - the register-offset constants for go, abort, continuous, settle, window, status and window_count.
- One sub-module, fa_down_counter: loadable down-counter with a zero flag.
  - Used three times: settle, window, timeout.

Test Plan:
- Single shot: settle=3, window=10, continuous=0; go, then irq 5 cycles after stop.
  - clear at T+1, start at T+5, stop at T+15.
  - window_done rises 1 cycle after irq rises; window_count=1; after ack, busy=0.
- Zero config: settle=0, window=0.
  - clear, start and stop pulses on 3 consecutive cycles; each exactly 1 cycle wide.
- Timeout: IRQ_TIMEOUT=16, irq held low.
  - timeout_err=1 and busy=0 about 17 cycles after stop; window_count=0.
  - next go clears timeout_err.
- Continuous: 3 windows with ack each time, then abort during the 4th MEASURE.
  - window_count=3; extra stop pulse on the abort; returns to IDLE; no 4th increment.
- Reset mid-MEASURE: assert s00_axi_aresetn=0.
  - all outputs 0 asynchronously; after release, go works normally.
- go and ack while busy/IDLE: go pulsed during SETTLE and ack pulsed in IDLE.
  - no state change, no extra clear pulse.
